// File: rtl/hci_bank_arbiter_if.sv
// hci_bank_arbiter_if: requester-side bundle of one TCDM bank (N_CH channels, flattened)
interface hci_bank_arbiter_if #(
  parameter int N_CH = 4,
  parameter int AW   = 12,
  parameter int DW   = 32,
  parameter int BW   = DW/8
);
  logic [N_CH-1:0]    req;
  logic [N_CH-1:0]    gnt;
  logic [N_CH*AW-1:0] add;
  logic [N_CH-1:0]    wen;
  logic [N_CH*BW-1:0] be;
  logic [N_CH*DW-1:0] data;
  logic [DW-1:0]      r_data;
  logic [N_CH-1:0]    r_valid;
  modport slave  (input  req, add, wen, be, data, output gnt, r_data, r_valid);
  modport master (output req, add, wen, be, data, input  gnt, r_data, r_valid);
endinterface

// File: rtl/hci_bank_arbiter.sv
// hci_bank_arbiter: N_CH-to-1 TCDM bank arbiter (fixed / round-robin / stall-flip) with response routing.
// Optional per-channel conflict counters: define HCI_BANK_ARB_PERF_CNT_EN.
module hci_bank_arbiter #(
  parameter int N_CH        = 4,
  parameter int AW          = 12,
  parameter int DW          = 32,
  parameter int BW          = DW/8,
  parameter int MEM_LATENCY = 1,
  parameter int STALL_W     = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  hci_bank_arbiter_if.slave  ch,
  output logic               mem_req_o,
  output logic [AW-1:0]      mem_add_o,
  output logic               mem_wen_o,
  output logic [BW-1:0]      mem_be_o,
  output logic [DW-1:0]      mem_data_o,
  input  logic               mem_gnt_i,
  input  logic [DW-1:0]      mem_r_data_i,
  input  logic [1:0]         arb_mode_i,
  input  logic [STALL_W-1:0] max_stall_i
`ifdef HCI_BANK_ARB_PERF_CNT_EN
  , output logic [N_CH*32-1:0] conflict_cnt_o
`endif
);
  localparam int IDW = $clog2(N_CH);
  localparam logic [1:0] M_RR = 2'b01, M_SF = 2'b10;
  logic [1:0]           mode_q;
  logic [IDW-1:0]       rr_q, rr_d, w;
  logic [STALL_W-1:0]   cnt_q, cnt_d;
  logic                 inv_q, inv_d, inv, push, lp_wait;
  logic [N_CH-1:0]      gnt;
  logic [MEM_LATENCY-1:0] vld_q;
  logic [IDW-1:0]       id_q [MEM_LATENCY];
  assign inv = inv_q & (mode_q == M_SF);
  // Round-robin: lowest requester overall, overridden by the lowest one at or above rr_q.
  always_comb begin
    w = '0;
    if (mode_q == M_RR) begin
      for (int i = N_CH-1; i >= 0; i--) if (ch.req[i]) w = IDW'(i);
      for (int i = N_CH-1; i >= 0; i--) if (ch.req[i] && IDW'(i) >= rr_q) w = IDW'(i);
    end else if (inv) begin
      for (int i = 0; i < N_CH; i++) if (ch.req[i]) w = IDW'(i);
    end else begin
      for (int i = N_CH-1; i >= 0; i--) if (ch.req[i]) w = IDW'(i);
    end
  end
  assign mem_req_o  = |ch.req;
  assign push       = mem_req_o & mem_gnt_i;
  assign gnt        = push ? N_CH'(1) << w : '0;
  assign ch.gnt     = gnt;
  assign mem_add_o  = ch.add[w*AW +: AW];
  assign mem_wen_o  = ch.wen[w];
  assign mem_be_o   = ch.be[w*BW +: BW];
  assign mem_data_o = ch.data[w*DW +: DW];
  assign ch.r_data  = mem_r_data_i;
  assign ch.r_valid = vld_q[MEM_LATENCY-1] ? N_CH'(1) << id_q[MEM_LATENCY-1] : '0;
  assign lp_wait    = inv ? ch.req[0] & ~gnt[0] : ch.req[N_CH-1] & ~gnt[N_CH-1];
  always_comb begin
    rr_d  = (mode_q == M_RR && push) ? (w == IDW'(N_CH-1) ? '0 : w + 1'b1) : rr_q;
    cnt_d = cnt_q;
    inv_d = 1'b0;
    if (mode_q == M_SF) begin
      inv_d = inv_q;
      if (!lp_wait) cnt_d = '0;
      else if (max_stall_i != '0 && cnt_q == max_stall_i) begin
        cnt_d = '0;
        inv_d = ~inv_q;
      end else if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q <= '0;
      rr_q   <= '0;
      cnt_q  <= '0;
      inv_q  <= 1'b0;
      vld_q  <= '0;
    end else if (clear_i) begin
      mode_q <= '0;
      rr_q   <= '0;
      cnt_q  <= '0;
      inv_q  <= 1'b0;
      vld_q  <= '0;
    end else begin
      mode_q <= arb_mode_i;
      rr_q   <= rr_d;
      cnt_q  <= cnt_d;
      inv_q  <= inv_d;
      vld_q  <= MEM_LATENCY'({vld_q, push});
    end
  end
  // Channel ids are only consumed alongside vld_q, so they need no reset.
  always_ff @(posedge clk_i) begin
    id_q[0] <= w;
    for (int i = 1; i < MEM_LATENCY; i++) id_q[i] <= id_q[i-1];
  end
`ifdef HCI_BANK_ARB_PERF_CNT_EN
  logic [31:0] cc_q [N_CH];
  for (genvar k = 0; k < N_CH; k++) begin : g_cc
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cc_q[k] <= '0;
      else if (clear_i) cc_q[k] <= '0;
      else if (ch.req[k] && !gnt[k] && cc_q[k] != '1) cc_q[k] <= cc_q[k] + 1'b1;
    end
    assign conflict_cnt_o[k*32 +: 32] = cc_q[k];
  end
`endif
endmodule

// File: doc/hci_bank_arbiter.md
Name: hci_bank_arbiter

Overview:
Per-bank TCDM arbiter that arbitrates N_CH requester channels onto one SRAM bank port. It is the next-generation replacement for the fixed two-way core/HWPE arbitration inside the heterogeneous interconnect. It adds runtime-selectable policy (fixed, round-robin, stall-flip), a programmable anti-starvation threshold, and response routing over a parametrised memory latency. One instance sits in front of each tcdm_sram_master bank.

Parameters:
N_CH, 4, number of requester channels (>=2)
AW, 12, bank-local address width
DW, 32, data width
BW, DW/8, byte-enable width
MEM_LATENCY, 1, cycles from bank grant to r_data valid (1..4)
STALL_W, 8, width of starvation counter and threshold

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous clear of all state
req_i  in  N_CH  per-channel request
gnt_o  out  N_CH  per-channel grant (one-hot or zero)
add_i  in  N_CH*AW  channel addresses, channel k at [k*AW +: AW]
wen_i  in  N_CH  1=read, 0=write
be_i  in  N_CH*BW  byte enables
data_i  in  N_CH*DW  write data
r_data_o  out  DW  read data, broadcast to all channels
r_valid_o  out  N_CH  per-channel response valid
mem_req_o  out  1  bank request
mem_add_o  out  AW  bank address
mem_wen_o  out  1  bank read/write
mem_be_o  out  BW  bank byte enables
mem_data_o  out  DW  bank write data
mem_gnt_i  in  1  bank grant (SRAM ties to 1)
mem_r_data_i  in  DW  bank read data, valid MEM_LATENCY cycles after grant
arb_mode_i  in  2  00 fixed-priority, 01 round-robin, 10 stall-flip, 11 reserved (treated as 00)
max_stall_i  in  STALL_W  stall-flip threshold, 0 = flip disabled

Behaviour:
- Reset: all outputs 0; rr_ptr=0; stall_cnt=0; prio_inv=0; latency pipeline empty.
- Combinational arbitration: winner w chosen among asserted req_i. mem_req_o = |req_i. mem_add/wen/be/data_o mux winner. gnt_o[w] = mem_gnt_i; no grant to any other channel.
- Fixed mode: lowest index wins. If prio_inv=1, the highest index wins instead.
- Round-robin mode: first requester at index >= rr_ptr, wrapping. On a granted transfer, rr_ptr <= (w+1) mod N_CH. rr_ptr holds when nothing is granted.
- Stall-flip mode: fixed priority with prio_inv.
  - stall_cnt increments each cycle the lowest-priority-class requester (channel N_CH-1 when prio_inv=0, channel 0 when prio_inv=1) requests and is not granted.
  - When stall_cnt == max_stall_i and max_stall_i != 0, prio_inv toggles next cycle and stall_cnt <= 0.
  - stall_cnt <= 0 whenever that channel is granted or stops requesting.
  - Counter saturates at its maximum value; it never wraps.
- A change of arb_mode_i takes effect next cycle. rr_ptr, stall_cnt and prio_inv are retained across a change, except that prio_inv is forced to 0 outside stall-flip mode.
- Response routing: a MEM_LATENCY-deep shift register of {valid, wen, winner id} is pushed on every cycle.
  - r_valid_o[id] asserts exactly MEM_LATENCY cycles after a granted transfer, for reads and writes alike.
  - Back-to-back grants produce back-to-back responses.
- r_data_o = mem_r_data_i passthrough.
- clear_i has the same effect as reset, synchronously. In-flight responses are dropped.
- Reset asserted mid-transfer: the pipeline is flushed and no r_valid_o is emitted after deassertion.
- mem_gnt_i=0: no gnt_o, no pipeline push. rr_ptr and stall_cnt treat the cycle as not granted.
- Single requester: always wins in every mode.

Optional Feature:
Macro HCI_BANK_ARB_PERF_CNT_EN.
- Defined: adds output conflict_cnt_o (N_CH*32). Per-channel 32-bit counters increment on each cycle the channel has req_i=1 and gnt_o=0. Counters saturate at 2^32-1 and reset via rst_ni or clear_i.
- Undefined: the port and counters are absent. Arbitration behaviour is identical in both builds.

Test Plan:
- Fixed mode, N_CH=4, req_i=4'b1010 held 3 cycles, mem_gnt_i=1 -> gnt_o=4'b0010 each cycle; r_valid_o[1] pulses in cycles 1..3 with MEM_LATENCY=1.
- Round-robin, req_i=4'b1111 held 8 cycles -> grant sequence ch0,1,2,3,0,1,2,3.
- Stall-flip, max_stall_i=3, req_i=4'b1001 continuous -> ch0 granted 4 cycles; then prio_inv=1 and ch3 is granted until it drops req; max_stall_i=0 -> ch3 never granted.
- MEM_LATENCY=3: read from ch2 at cycle t with mem_r_data_i=32'hDEADBEEF at t+3 -> r_valid_o=4'b0100 and r_data_o=32'hDEADBEEF at t+3 only.
- mem_gnt_i=0 for 2 cycles with req_i=4'b0001 -> gnt_o=0, no r_valid_o; the grant resumes when mem_gnt_i=1.
- rst_ni pulsed low one cycle after a read grant (MEM_LATENCY=2) -> no r_valid_o afterwards. With the macro defined, all conflict counters read 0 after reset.
